// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: next-PC selection, trap/mret redirect,
// misaligned-target trapping and a small circular return-address stack.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap,
  input  logic            mret,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_four,
  output logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  localparam int unsigned   PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   ras_cnt;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] sel_target;
  logic            take_trap;
  logic            misalign;
  logic            ras_en;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_repl;

  assign pc_plus_four = pc + XLEN'(4);
  assign pc_target    = pc + imm_ext;
  assign jalr_sum     = rs1_data + imm_ext;
  assign jalr_target  = {jalr_sum[XLEN-1:1], 1'b0};

  // ptr is the next write slot; the top entry sits just below it
  assign top_idx   = ras_ptr - PW'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

  // Next-PC priority: trap, mret, stall, jalr, branch, sequential
  always_comb begin
    pc_next    = pc_plus_four;
    sel_target = pc_plus_four;
    take_trap  = 1'b0;
    misalign   = 1'b0;
    ras_en     = 1'b0;
    if (trap) begin
      pc_next   = TRAP_VECTOR;
      take_trap = 1'b1;
    end else if (mret) begin
      pc_next = epc;
    end else if (stall) begin
      pc_next = pc;
    end else begin
      ras_en = 1'b1;
      if (jalr_en) begin
        sel_target = jalr_target;
      end else if (branch_taken) begin
        sel_target = pc_target;
      end
      pc_next = sel_target;
      if ((jalr_en || branch_taken) && (sel_target[1:0] != 2'b00)) begin
        pc_next   = TRAP_VECTOR;
        take_trap = 1'b1;
        misalign  = 1'b1;
        ras_en    = 1'b0;
      end
    end
  end

  // A call+return pair on an empty stack degenerates to a plain push
  assign ras_push = ras_en && is_call && (!is_ret || ras_empty);
  assign ras_repl = ras_en && is_call && is_ret && !ras_empty;
  assign ras_pop  = ras_en && is_ret && !is_call && !ras_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_VECTOR;
      epc          <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_next;
      misalign_err <= misalign;
      if (take_trap) begin
        epc <= pc;
      end
    end
  end

  // Circular stack: a push when full overwrites the oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= pc_plus_four;
      ras_ptr          <= ras_ptr + PW'(1);
      if (ras_cnt != RAS_FULL) begin
        ras_cnt <= ras_cnt + CW'(1);
      end
    end else if (ras_repl) begin
      ras_mem[top_idx] <= pc_plus_four;
    end else if (ras_pop) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

endmodule
